// File: rtl/fpu_instr_responder_if.sv
// CPU<->FPU coprocessor bundle: instruction/operand/result handshake,
// control/status words, and the execution-core start/done channel.
interface fpu_instr_responder_if;
    logic        instr_valid;
    logic [7:0]  opcode;
    logic [7:0]  modrm;
    logic        instr_ack;
    logic        data_write;
    logic [79:0] data_in;
    logic [2:0]  data_size;
    logic        data_read;
    logic [79:0] data_out;
    logic        data_ready;
    logic        busy;
    logic        ready;
    logic        wait_req;
    logic [15:0] status_word;
    logic [15:0] control_word;
    logic        ctrl_write;
    logic        exception;
    logic        irq;
    logic        core_start;
    logic [7:0]  core_opcode;
    logic [7:0]  core_modrm;
    logic [79:0] core_operand;
    logic        core_done;
    logic [79:0] core_result;
    logic [15:0] core_status;

    // FPU side
    modport slave (
        input  instr_valid, opcode, modrm,
        input  data_write, data_in, data_size, data_read,
        input  wait_req, control_word, ctrl_write,
        input  core_done, core_result, core_status,
        output instr_ack, data_out, data_ready,
        output busy, ready, status_word, exception, irq,
        output core_start, core_opcode, core_modrm, core_operand
    );

    // CPU adapter and execution core side
    modport master (
        output instr_valid, opcode, modrm,
        output data_write, data_in, data_size, data_read,
        output wait_req, control_word, ctrl_write,
        output core_done, core_result, core_status,
        input  instr_ack, data_out, data_ready,
        input  busy, ready, status_word, exception, irq,
        input  core_start, core_opcode, core_modrm, core_operand
    );
endinterface

// File: rtl/fpu_instr_responder.sv
// FPU-side coprocessor endpoint: accepts ESC instructions, owns CW/SW,
// sequences one instruction into the core, returns store results.
// Ports: clk, reset_n (async active-low), bus (fpu_instr_responder_if.slave).
module fpu_instr_responder #(
    parameter int unsigned OPERAND_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    fpu_instr_responder_if.slave        bus
);
    localparam logic [15:0] TMO_LAST = 16'(OPERAND_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_OPERAND, S_EXECUTE, S_RESULT
    } state_t;

    typedef enum logic [2:0] {
        K_WAIT, K_FINIT, K_FCLEX, K_FSTCW,
        K_FSTSW, K_LOAD, K_FLDCW, K_CORE
    } kind_t;

    state_t      r_state;
    logic        r_ack;
    logic        r_data_ready;
    logic        r_busy;
    logic        r_start;
    logic [7:0]  r_opcode;
    logic [7:0]  r_modrm;
    logic [79:0] r_operand;
    logic [79:0] r_data_out;
    logic [15:0] r_cw;
    logic [6:0]  r_sw_top;
    logic        r_sw_sf;
    logic [5:0]  r_sw_exc;
    logic [2:0]  r_need_size;
    logic        r_fldcw;
    logic        r_store;
    logic [15:0] r_tmo;

    logic        w_mem;
    logic [2:0]  w_reg;
    kind_t       w_kind;
    logic [2:0]  w_size;
    logic        w_store;
    logic        w_es;
    logic [15:0] w_sw;
    logic        w_unused;

    assign w_mem = (r_modrm[7:6] != 2'b11);
    assign w_reg = r_modrm[5:3];

    always_comb begin
        w_kind  = K_CORE;
        w_size  = 3'd0;
        w_store = 1'b0;
        if (r_opcode == 8'h9B) begin
            w_kind = K_WAIT;
        end else if (r_opcode == 8'hDB && r_modrm == 8'hE3) begin
            w_kind = K_FINIT;
        end else if (r_opcode == 8'hDB && r_modrm == 8'hE2) begin
            w_kind = K_FCLEX;
        end else if (r_opcode == 8'hDF && r_modrm == 8'hE0) begin
            w_kind = K_FSTSW;
        end else if (w_mem) begin
            case (r_opcode)
                8'hD8: begin
                    w_kind = K_LOAD;
                    w_size = 3'd1;
                end
                8'hD9: begin
                    case (w_reg)
                        3'd0: begin
                            w_kind = K_LOAD;
                            w_size = 3'd1;
                        end
                        3'd5:       w_kind  = K_FLDCW;
                        3'd7:       w_kind  = K_FSTCW;
                        3'd2, 3'd3: w_store = 1'b1;
                        default: ;
                    endcase
                end
                8'hDB: begin
                    case (w_reg)
                        3'd5: begin
                            w_kind = K_LOAD;
                            w_size = 3'd3;
                        end
                        3'd7:    w_store = 1'b1;
                        default: ;
                    endcase
                end
                8'hDD: begin
                    case (w_reg)
                        3'd0: begin
                            w_kind = K_LOAD;
                            w_size = 3'd2;
                        end
                        3'd7:       w_kind  = K_FSTSW;
                        3'd2, 3'd3: w_store = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // ES summarises unmasked sticky exceptions; B mirrors busy.
    assign w_es = |(r_sw_exc & ~r_cw[5:0]);
    assign w_sw = {r_busy, r_sw_top, w_es, r_sw_sf, r_sw_exc};

    // wait_req is informational; SW[15]/SW[7] are derived locally.
    assign w_unused = ^{bus.wait_req, bus.core_status[15], bus.core_status[7]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ack        <= 1'b0;
            r_data_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_start      <= 1'b0;
            r_opcode     <= 8'h00;
            r_modrm      <= 8'h00;
            r_operand    <= '0;
            r_data_out   <= '0;
            r_cw         <= 16'h037F;
            r_sw_top     <= '0;
            r_sw_sf      <= 1'b0;
            r_sw_exc     <= '0;
            r_need_size  <= '0;
            r_fldcw      <= 1'b0;
            r_store      <= 1'b0;
            r_tmo        <= '0;
        end else begin
            r_ack        <= 1'b0;
            r_start      <= 1'b0;
            r_data_ready <= 1'b0;
            // FINIT / FLDCW below override a same-cycle CW write.
            if (bus.ctrl_write) begin
                r_cw <= bus.control_word;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        r_opcode <= bus.opcode;
                        r_modrm  <= bus.modrm;
                        r_ack    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_need_size <= w_size;
                    r_fldcw     <= (w_kind == K_FLDCW);
                    r_store     <= w_store;
                    r_tmo       <= '0;
                    case (w_kind)
                        K_WAIT: begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                        K_FINIT: begin
                            r_sw_top <= '0;
                            r_sw_sf  <= 1'b0;
                            r_sw_exc <= '0;
                            r_cw     <= 16'h037F;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                        K_FCLEX: begin
                            r_sw_sf  <= 1'b0;
                            r_sw_exc <= '0;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                        K_FSTCW: begin
                            r_data_out <= {64'h0, r_cw};
                            r_busy     <= 1'b0;
                            r_state    <= S_RESULT;
                        end
                        K_FSTSW: begin
                            r_data_out <= {64'h0, w_sw};
                            r_busy     <= 1'b0;
                            r_state    <= S_RESULT;
                        end
                        K_LOAD, K_FLDCW: begin
                            r_state <= S_OPERAND;
                        end
                        default: begin
                            r_start <= 1'b1;
                            r_state <= S_EXECUTE;
                        end
                    endcase
                end
                S_OPERAND: begin
                    if (bus.data_write) begin
                        if (bus.data_size == r_need_size) begin
                            r_operand <= bus.data_in;
                            if (r_fldcw) begin
                                r_cw    <= bus.data_in[15:0];
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_start <= 1'b1;
                                r_state <= S_EXECUTE;
                            end
                        end else begin
                            r_sw_exc[0] <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_sw_exc[0] <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                S_EXECUTE: begin
                    if (bus.core_done) begin
                        r_sw_top <= bus.core_status[14:8];
                        r_sw_sf  <= bus.core_status[6];
                        r_sw_exc <= r_sw_exc | bus.core_status[5:0];
                        r_busy   <= 1'b0;
                        if (r_store) begin
                            r_data_out <= bus.core_result;
                            r_state    <= S_RESULT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RESULT: begin
                    if (bus.data_read) begin
                        r_data_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ack    = r_ack;
    assign bus.data_out     = r_data_out;
    assign bus.data_ready   = r_data_ready;
    assign bus.busy         = r_busy;
    assign bus.ready        = ~r_busy;
    assign bus.status_word  = w_sw;
    assign bus.exception    = w_es;
    assign bus.irq          = w_es & ~r_cw[7];
    assign bus.core_start   = r_start;
    assign bus.core_opcode  = r_opcode;
    assign bus.core_modrm   = r_modrm;
    assign bus.core_operand = r_operand;
endmodule

// File: tb/tb_fpu_instr_responder.sv
// Self-checking bench for fpu_instr_responder: directed steps followed by
// randomized instructions checked against an instruction-level model.
module tb_fpu_instr_responder;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fpu_instr_responder_if bus();

    fpu_instr_responder #(.OPERAND_TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef enum {
        K_WAIT, K_FINIT, K_FCLEX, K_FSTCW, K_FSTSW,
        K_LOAD, K_FLDCW, K_STORE, K_ARITH
    } kind_e;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_cw;
    logic [15:0] m_sw;
    logic        g_cwdec = 1'b0;
    logic [15:0] g_cwval = 16'h0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk80(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status word as software should see it, from the model's sticky state.
    function automatic logic [15:0] sw_exp(input logic b);
        logic es;
        es = |(m_sw[5:0] & ~m_cw[5:0]);
        return {b, m_sw[14:8], es, m_sw[6:0]};
    endfunction

    // Instruction classes straight from the opcode table.
    task automatic classify(input logic [7:0] op, input logic [7:0] md,
                            output kind_e k, output logic [2:0] sz);
        logic       mem;
        logic [2:0] r;
        mem = (md[7:6] != 2'b11);
        r   = md[5:3];
        k   = K_ARITH;
        sz  = 3'd0;
        if (op == 8'h9B) k = K_WAIT;
        else if (op == 8'hDB && md == 8'hE3) k = K_FINIT;
        else if (op == 8'hDB && md == 8'hE2) k = K_FCLEX;
        else if (op == 8'hDF && md == 8'hE0) k = K_FSTSW;
        else if (mem && op == 8'hD8) begin k = K_LOAD; sz = 3'd1; end
        else if (mem && op == 8'hD9 && r == 3'd0) begin k = K_LOAD; sz = 3'd1; end
        else if (mem && op == 8'hD9 && r == 3'd5) k = K_FLDCW;
        else if (mem && op == 8'hD9 && r == 3'd7) k = K_FSTCW;
        else if (mem && op == 8'hD9 && (r == 3'd2 || r == 3'd3)) k = K_STORE;
        else if (mem && op == 8'hDB && r == 3'd5) begin k = K_LOAD; sz = 3'd3; end
        else if (mem && op == 8'hDB && r == 3'd7) k = K_STORE;
        else if (mem && op == 8'hDD && r == 3'd0) begin k = K_LOAD; sz = 3'd2; end
        else if (mem && op == 8'hDD && r == 3'd7) k = K_FSTSW;
        else if (mem && op == 8'hDD && (r == 3'd2 || r == 3'd3)) k = K_STORE;
    endtask

    // Offer an instruction until acked; returns just after the decode edge.
    task automatic issue(input logic [7:0] op, input logic [7:0] md);
        logic got;
        got = 1'b0;
        bus.opcode      = op;
        bus.modrm       = md;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (bus.instr_ack) got = 1'b1;
        end
        chk1("ack_seen", got, 1'b1);
        chk1("busy_at_ack", bus.busy, 1'b1);
        bus.instr_valid = 1'b0;
        if (g_cwdec) begin
            bus.control_word = g_cwval;
            bus.ctrl_write   = 1'b1;
            m_cw             = g_cwval;
        end
        tick();
        bus.ctrl_write = 1'b0;
        chk1("ack_one_pulse", bus.instr_ack, 1'b0);
        chk16("core_latch", {bus.core_opcode, bus.core_modrm}, {op, md});
    endtask

    task automatic write_cw(input logic [15:0] v);
        bus.control_word = v;
        bus.ctrl_write   = 1'b1;
        tick();
        bus.ctrl_write = 1'b0;
        m_cw = v;
        chk16("sw_after_cw", bus.status_word, sw_exp(1'b0));
    endtask

    // szsel < 0 means no operand is ever supplied.
    task automatic run(input logic [7:0] op, input logic [7:0] md, input int szsel,
                       input logic [79:0] data, input logic [79:0] res,
                       input logic [15:0] cst);
        kind_e       k;
        logic [2:0]  need;
        logic [79:0] exp_do;
        logic        res_phase;
        logic        do_exec;
        classify(op, md, k, need);
        res_phase = 1'b0;
        do_exec   = 1'b0;
        exp_do    = '0;
        if (k == K_FSTSW) exp_do = {64'h0, sw_exp(1'b1)};
        if (k == K_FSTCW) exp_do = {64'h0, m_cw};
        issue(op, md);
        case (k)
            K_WAIT: ;
            K_FINIT: begin
                m_sw = 16'h0;
                m_cw = 16'h037F;
            end
            K_FCLEX: m_sw[7:0] = 8'h0;
            K_FSTCW, K_FSTSW: res_phase = 1'b1;
            K_LOAD, K_FLDCW: begin
                chk1("operand_busy", bus.busy, 1'b1);
                chk1("operand_nostart", bus.core_start, 1'b0);
                if (szsel < 0) begin
                    for (int i = 1; i < TMO; i++) tick();
                    chk1("tmo_not_yet", bus.busy, 1'b1);
                    tick();
                    m_sw[0] = 1'b1;
                end else begin
                    bus.data_write = 1'b1;
                    bus.data_size  = 3'(szsel);
                    bus.data_in    = data;
                    tick();
                    bus.data_write = 1'b0;
                    if (3'(szsel) != need) begin
                        m_sw[0] = 1'b1;
                    end else if (k == K_FLDCW) begin
                        m_cw = data[15:0];
                    end else begin
                        chk1("core_start", bus.core_start, 1'b1);
                        chk80("core_operand", bus.core_operand, data);
                        do_exec = 1'b1;
                    end
                end
                if (!do_exec) chk1("abort_nostart", bus.core_start, 1'b0);
            end
            default: begin
                chk1("core_start", bus.core_start, 1'b1);
                do_exec = 1'b1;
            end
        endcase
        if (do_exec) begin
            chk1("exec_busy", bus.busy, 1'b1);
            bus.core_done   = 1'b1;
            bus.core_result = res;
            bus.core_status = cst;
            tick();
            bus.core_done = 1'b0;
            chk1("start_one_pulse", bus.core_start, 1'b0);
            m_sw[14:8] = cst[14:8];
            m_sw[6]    = cst[6];
            m_sw[5:0]  = m_sw[5:0] | cst[5:0];
            if (k == K_STORE) begin
                res_phase = 1'b1;
                exp_do    = res;
            end
        end
        if (res_phase) begin
            chk1("result_busy", bus.busy, 1'b0);
            chk1("result_ready", bus.ready, 1'b1);
            chk1("result_early", bus.data_ready, 1'b0);
            bus.data_read = 1'b1;
            tick();
            bus.data_read = 1'b0;
            chk1("data_ready", bus.data_ready, 1'b1);
            chk80("data_out", bus.data_out, exp_do);
            tick();
            chk1("data_ready_pulse", bus.data_ready, 1'b0);
        end else begin
            chk1("no_data_ready", bus.data_ready, 1'b0);
        end
        chk1("idle_busy", bus.busy, 1'b0);
        chk1("idle_ready", bus.ready, 1'b1);
        chk16("status_word", bus.status_word, sw_exp(1'b0));
        chk1("exception", bus.exception, |(m_sw[5:0] & ~m_cw[5:0]));
        chk1("irq", bus.irq, (|(m_sw[5:0] & ~m_cw[5:0])) & ~m_cw[7]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_ack"}, bus.instr_ack, 1'b0);
        chk1({tag, "_dr"}, bus.data_ready, 1'b0);
        chk1({tag, "_start"}, bus.core_start, 1'b0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_ready"}, bus.ready, 1'b1);
        chk80({tag, "_dout"}, bus.data_out, 80'h0);
        chk80({tag, "_operand"}, bus.core_operand, 80'h0);
        chk16({tag, "_opmodrm"}, {bus.core_opcode, bus.core_modrm}, 16'h0);
        chk16({tag, "_sw"}, bus.status_word, 16'h0);
        chk1({tag, "_exc"}, bus.exception, 1'b0);
        chk1({tag, "_irq"}, bus.irq, 1'b0);
    endtask

    initial begin
        logic [7:0]  op;
        logic [7:0]  md;
        logic [79:0] exp_do;
        kind_e       k;
        logic [2:0]  need;
        int          szsel;

        bus.instr_valid  = 1'b0;
        bus.opcode       = 8'h0;
        bus.modrm        = 8'h0;
        bus.data_write   = 1'b0;
        bus.data_in      = '0;
        bus.data_size    = 3'd0;
        bus.data_read    = 1'b0;
        bus.wait_req     = 1'b0;
        bus.control_word = 16'h0;
        bus.ctrl_write   = 1'b0;
        bus.core_done    = 1'b0;
        bus.core_result  = '0;
        bus.core_status  = 16'h0;
        m_cw = 16'h037F;
        m_sw = 16'h0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // FSTCW reads the reset control word
        run(8'hD9, 8'h38, 0, '0, '0, 16'h0);

        // FSTSW; an offer made during RESULT waits for IDLE
        exp_do = {64'h0, sw_exp(1'b1)};
        issue(8'hDD, 8'h38);
        bus.opcode      = 8'h9B;
        bus.modrm       = 8'h00;
        bus.instr_valid = 1'b1;
        tick();
        tick();
        chk1("no_ack_in_result", bus.instr_ack, 1'b0);
        bus.data_read = 1'b1;
        tick();
        bus.data_read = 1'b0;
        chk1("fstsw_ready", bus.data_ready, 1'b1);
        chk80("fstsw_out", bus.data_out, exp_do);
        chk1("fstsw_no_ack", bus.instr_ack, 1'b0);
        tick();
        chk1("ack_after_result", bus.instr_ack, 1'b1);
        bus.instr_valid = 1'b0;
        tick();
        chk1("fwait_done", bus.busy, 1'b0);

        // FLD m32, FST m64 with an invalid-operation flag from the core
        run(8'hD9, 8'h06, 1, 80'h3F800000, '0, 16'h0);
        run(8'hDD, 8'h16, 0, '0, 80'h0000_4000_0000_0000_0000, 16'h0001);
        chk1("ie_masked", bus.exception, 1'b0);
        write_cw(16'h037E);
        chk1("ie_unmasked_exc", bus.exception, 1'b1);
        chk1("ie_unmasked_irq", bus.irq, 1'b1);
        write_cw(16'h03FE);
        chk1("irq_masked_by_bit7", bus.irq, 1'b0);
        write_cw(16'h037F);

        // Operand size mismatch, then operand timeout
        run(8'hDB, 8'h2E, 1, 80'h1234, '0, 16'h0);
        run(8'hDB, 8'h2E, -1, '0, '0, 16'h0);

        // FCLEX clears flags; FINIT beats a same-cycle CW write
        write_cw(16'h0370);
        run(8'hDB, 8'hE2, 0, '0, '0, 16'h0);
        chk1("fclex_exc", bus.exception, 1'b0);
        g_cwdec = 1'b1;
        g_cwval = 16'h0000;
        run(8'hDB, 8'hE3, 0, '0, '0, 16'h0);
        g_cwdec = 1'b0;
        run(8'hD9, 8'h38, 0, '0, '0, 16'h0);

        // FLDCW via operand path, read back with FSTCW
        run(8'hD9, 8'h2E, 0, 80'h0000_0000_0000_0000_0272, '0, 16'h0);
        run(8'hD9, 8'h38, 0, '0, '0, 16'h0);

        // Reset in EXECUTE aborts; a late core_done has no effect
        issue(8'hD8, 8'hC1);
        chk1("pre_reset_start", bus.core_start, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        tick();
        reset_n = 1'b1;
        m_cw = 16'h037F;
        m_sw = 16'h0;
        tick();
        bus.core_done   = 1'b1;
        bus.core_result = 80'hFFFF;
        bus.core_status = 16'h3F3F;
        tick();
        bus.core_done = 1'b0;
        tick();
        chk_reset_outputs("late_done");
        run(8'hD9, 8'h38, 0, '0, '0, 16'h0);

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) write_cw(16'($urandom));
            case ($urandom_range(0, 15))
                0: begin op = 8'h9B; md = 8'($urandom); end
                1: begin op = 8'hDB; md = 8'hE3; end
                2: begin op = 8'hDB; md = 8'hE2; end
                3: begin op = 8'hDF; md = 8'hE0; end
                default: begin
                    op = 8'hD8 + 8'($urandom_range(0, 7));
                    md = 8'($urandom);
                end
            endcase
            classify(op, md, k, need);
            case ($urandom_range(0, 9))
                0:       szsel = -1;
                1:       szsel = int'($urandom_range(0, 7));
                default: szsel = int'(need);
            endcase
            run(op, md, szsel,
                {16'($urandom), 32'($urandom), 32'($urandom)},
                {16'($urandom), 32'($urandom), 32'($urandom)},
                16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
